// File: rtl/lock_sequencer_fsm.sv
// Safe-lock top-level sequencer.
// This block steps keypad digits into the external input shift register and checks the
// comparator's match result. It counts failed attempts and enforces a timed lockout, drives
// the lock output with auto-relock, and loads a new passcode into the stored-code register.
// The "program" pulse is named program_req because `program` is a reserved word in
// SystemVerilog.
module lock_sequencer_fsm #(
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int UNLOCK_CYCLES  = 500
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              digit_valid,
  input  logic                              enter,
  input  logic                              cancel,
  input  logic                              relock,
  input  logic                              program_req,
  input  logic                              match,
  output logic                              shift_en,
  output logic                              shift_clr,
  output logic                              store_load,
  output logic                              unlocked,
  output logic                              alarm,
  output logic                              fail_pulse,
  output logic [2:0]                        state,
  output logic [2:0]                        digit_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left
);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_ENTRY    = 3'd1,
    S_CHECK    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_PROGRAM  = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  localparam int AW        = $clog2(MAX_ATTEMPTS + 1);
  localparam int TIMER_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX);

  localparam logic [AW-1:0] ATT_FULL  = AW'(MAX_ATTEMPTS);
  localparam logic [2:0]    DIG_FULL  = 3'(NUM_DIGITS);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] UNL_LAST  = TW'(UNLOCK_CYCLES - 1);

  state_t        state_q;
  logic [TW-1:0] timer;
  logic          digit_full;
  logic          keypad_state;
  logic          unlock_timeout;

  assign state = state_q;

  // Digit acceptance and shift-register clearing, decided in the same cycle as the keypad pulse.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shift_clr      = reset | store_load;
    digit_full     = (digit_count == DIG_FULL);
    keypad_state   = (state_q == S_LOCKED) || (state_q == S_ENTRY) || (state_q == S_PROGRAM);
    unlock_timeout = (state_q == S_UNLOCKED) && (timer == UNL_LAST);
    shift_en       = ~reset & digit_valid & ~enter & ~cancel & keypad_state &
                     (digit_count < DIG_FULL);
    case (state_q)
      S_ENTRY:    shift_clr = shift_clr | cancel;
      S_CHECK:    shift_clr = 1'b1;
      S_UNLOCKED: shift_clr = shift_clr | relock | unlock_timeout | program_req;
      S_PROGRAM:  shift_clr = shift_clr | cancel;
      default:    ;
    endcase
  end

  // Main controller: state, digit/attempt counters, shared timer and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      state_q       <= S_LOCKED;
      digit_count   <= '0;
      attempts_left <= ATT_FULL;
      timer         <= '0;
      unlocked      <= 1'b0;
      alarm         <= 1'b0;
      fail_pulse    <= 1'b0;
      store_load    <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      store_load <= 1'b0;
      case (state_q)
        S_LOCKED: begin
          // Only the first accepted digit moves us on; a bare enter or cancel does nothing.
          if (shift_en) begin
            digit_count <= digit_count + 3'd1;
            state_q     <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (cancel) begin
            digit_count <= '0;
            state_q     <= S_LOCKED;
          end else if (enter) begin
            state_q <= S_CHECK;
          end else if (shift_en) begin
            digit_count <= digit_count + 3'd1;
          end
        end

        S_CHECK: begin
          // One cycle here lets match settle on the registered shift-register contents.
          digit_count <= '0;
          if (digit_full && match) begin
            attempts_left <= ATT_FULL;
            unlocked      <= 1'b1;
            state_q       <= S_UNLOCKED;
          end else begin
            fail_pulse    <= 1'b1;
            attempts_left <= attempts_left - AW'(1);
            if (attempts_left == AW'(1)) begin
              alarm   <= 1'b1;
              state_q <= S_LOCKOUT;
            end else begin
              state_q <= S_LOCKED;
            end
          end
        end

        S_UNLOCKED: begin
          if (relock || unlock_timeout) begin
            unlocked <= 1'b0;
            timer    <= '0;
            state_q  <= S_LOCKED;
          end else if (program_req) begin
            digit_count <= '0;
            timer       <= '0;
            state_q     <= S_PROGRAM;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_PROGRAM: begin
          // No timeout while a new code is being keyed in; the lock stays open.
          if (cancel) begin
            digit_count <= '0;
            timer       <= '0;
            state_q     <= S_UNLOCKED;
          end else if (enter) begin
            if (digit_full) begin
              store_load    <= 1'b1;
              unlocked      <= 1'b0;
              digit_count   <= '0;
              attempts_left <= ATT_FULL;
              state_q       <= S_LOCKED;
            end
          end else if (shift_en) begin
            digit_count <= digit_count + 3'd1;
          end
        end

        S_LOCKOUT: begin
          if (timer == LOCK_LAST) begin
            alarm         <= 1'b0;
            attempts_left <= ATT_FULL;
            timer         <= '0;
            state_q       <= S_LOCKED;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state_q     <= S_LOCKED;
          digit_count <= '0;
          timer       <= '0;
          unlocked    <= 1'b0;
          alarm       <= 1'b0;
        end
      endcase
    end
  end

endmodule
